aidan_mcnay_prime_feeder: RTL and testbench

Upstream driver for the prime detector. Accepts a parallel candidate number on a val/rdy request stream and serialises it MSB-first onto the detector's SDI/SCLK/CS pins. It then toggles the detector's ready pin, waits for the synchronised done, and returns is_prime on a val/rdy response stream. This lets a host, or an on-chip test sequencer, drive the detector without bit-banging the serial pins.

---
 rtl/aidan_mcnay_prime_feeder.sv | 159 +++++++++++++++
 tb/tb_aidan_mcnay_prime_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_prime_feeder.sv
// Serialises a candidate number MSB-first to the prime detector, toggles its ready pin and returns the verdict.
// Optional macro PRIME_FEEDER_TIMEOUT_EN bounds the wait for done and flags a timed-out verdict.
module aidan_mcnay_prime_feeder #(
    parameter int nbits          = 32,
    parameter int HALF_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [nbits-1:0] req_num,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic             resp_is_prime,
    output logic             resp_timeout,
    output logic             sdi,
    output logic             sclk,
    output logic             cs_n,
    output logic             ready_tgl,
    input  logic             done_in,
    input  logic             is_prime_in
);
    localparam int BW = $clog2(nbits) + 1;
    localparam int HW = $clog2(HALF_CYCLES);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_HI, SHIFT_LO, TRIGGER, WAIT_CLR, WAIT_DONE, RESP
    } state_t;

    state_t           state;
    logic [nbits-1:0] shreg;
    logic [nbits-1:0] shreg_sh;
    logic [BW-1:0]    bcnt;
    logic [HW-1:0]    hc;
    logic             half_done;
    logic             done_meta, done_s, prime_meta, prime_s;

    assign shreg_sh  = shreg << 1;
    assign half_done = (hc == HW'(HALF_CYCLES - 1));
    assign req_rdy   = (state == IDLE) && !reset;

`ifdef PRIME_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          tmo_hit;
    assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bcnt          <= '0;
            hc            <= '0;
            resp_val      <= 1'b0;
            resp_is_prime <= 1'b0;
            sdi           <= 1'b0;
            sclk          <= 1'b0;
            cs_n          <= 1'b1;
            ready_tgl     <= 1'b0;
            done_meta     <= 1'b0;
            done_s        <= 1'b0;
            prime_meta    <= 1'b0;
            prime_s       <= 1'b0;
`ifdef PRIME_FEEDER_TIMEOUT_EN
            tcnt          <= '0;
            resp_timeout  <= 1'b0;
`endif
        end else begin
            done_meta  <= done_in;
            done_s     <= done_meta;
            prime_meta <= is_prime_in;
            prime_s    <= prime_meta;
            case (state)
                IDLE: if (req_val) begin
                    shreg <= req_num;
                    sdi   <= req_num[nbits-1];
                    cs_n  <= 1'b0;
                    sclk  <= 1'b0;
                    bcnt  <= '0;
                    hc    <= '0;
                    state <= SETUP;
                end
                SETUP, SHIFT_LO: if (half_done) begin
                    hc <= '0;
                    if (state == SETUP || bcnt < BW'(nbits)) begin
                        sclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end else begin
                        cs_n  <= 1'b1;
                        state <= TRIGGER;
                    end
                end else begin
                    hc <= hc + 1'b1;
                end
                // sdi only moves on the falling sclk edge, so the detector samples a settled bit
                SHIFT_HI: if (half_done) begin
                    hc    <= '0;
                    sclk  <= 1'b0;
                    shreg <= shreg_sh;
                    sdi   <= shreg_sh[nbits-1];
                    if (bcnt != '1) bcnt <= bcnt + 1'b1;
                    state <= SHIFT_LO;
                end else begin
                    hc <= hc + 1'b1;
                end
                TRIGGER: begin
                    ready_tgl <= ~ready_tgl;
                    state     <= WAIT_CLR;
`ifdef PRIME_FEEDER_TIMEOUT_EN
                    tcnt      <= '0;
`endif
                end
                // a done still high from the previous number must fall before a new one counts
                WAIT_CLR: begin
                    if (!done_s) state <= WAIT_DONE;
`ifdef PRIME_FEEDER_TIMEOUT_EN
                    if (tmo_hit) begin
                        resp_val      <= 1'b1;
                        resp_is_prime <= 1'b0;
                        resp_timeout  <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (done_s) begin
                        resp_val      <= 1'b1;
                        resp_is_prime <= prime_s;
`ifdef PRIME_FEEDER_TIMEOUT_EN
                        resp_timeout  <= 1'b0;
`endif
                        state         <= RESP;
                    end
`ifdef PRIME_FEEDER_TIMEOUT_EN
                    else if (tmo_hit) begin
                        resp_val      <= 1'b1;
                        resp_is_prime <= 1'b0;
                        resp_timeout  <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                RESP: if (resp_rdy) begin
                    resp_val <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aidan_mcnay_prime_feeder.sv
// Directed plus random requests against a bench-side detector model and primality reference.
module tb_aidan_mcnay_prime_feeder;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       reset, req_val, resp_rdy, done_in, is_prime_in;
    logic [7:0] req_num;
    logic       req_rdy, resp_val, resp_is_prime, resp_timeout, sdi, sclk, cs_n, ready_tgl;

    int         checks = 0;
    int         errors = 0;
    logic       exp_tgl = 1'b0;

    // serial-side monitor state, sampled on the falling clk edge
    int         edges = 0;
    int         hp_bad = 0;
    int         run = 0;
    logic [7:0] bits = '0;
    logic       prev_sclk = 1'b0;

    aidan_mcnay_prime_feeder #(.nbits(8), .HALF_CYCLES(H), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_num(req_num),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_is_prime(resp_is_prime),
        .resp_timeout(resp_timeout), .sdi(sdi), .sclk(sclk), .cs_n(cs_n),
        .ready_tgl(ready_tgl), .done_in(done_in), .is_prime_in(is_prime_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!cs_n && sclk && !prev_sclk) begin
            edges <= edges + 1;
            bits  <= {bits[6:0], sdi};
        end
        if (cs_n) run <= 0;
        else if (sclk != prev_sclk) begin
            if (run != H) hp_bad <= hp_bad + 1;
            run <= 1;
        end else run <= run + 1;
        prev_sclk <= sclk;
    end

    function automatic logic prime_ref(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // hand over one request and follow it through serialisation and the ready toggle
    task automatic send(input logic [7:0] num, input bit pulse);
        int  n;
        int  e0, b0;
        bit  pulsed;
        e0 = edges;
        b0 = hp_bad;
        n = 0;
        while (!req_rdy && n < 100) begin @(negedge clk); n++; end
        check("req_rdy_idle", req_rdy, 1);
        req_val = 1'b1;
        req_num = num;
        @(negedge clk);
        req_val = 1'b0;
        check("cs_n_low", cs_n, 0);
        pulsed = 0;
        n = 0;
        while (!cs_n && n < 500) begin
            if (pulse && !pulsed && sclk) begin
                req_val = 1'b1;
                req_num = 8'h07;
                pulsed  = 1;
                check("req_rdy_busy", req_rdy, 0);
            end else req_val = 1'b0;
            @(negedge clk);
            n++;
        end
        req_val = 1'b0;
        check("cs_n_rise", cs_n, 1);
        check("sclk_edges", edges - e0, 8);
        check("serial_bits", bits, num);
        check("half_period", hp_bad - b0, 0);
        check("tgl_before", ready_tgl, exp_tgl);
        @(negedge clk);
        exp_tgl = ~exp_tgl;
        check("tgl_after", ready_tgl, exp_tgl);
    endtask

    task automatic txn(input logic [7:0] num, input logic verdict, input int dly,
                       input int stall, input bit pulse);
        int n;
        bit early, unstable;
        send(num, pulse);
        early = 0;
        if (done_in) begin
            repeat (4) begin @(negedge clk); if (resp_val) early = 1; end
            done_in = 1'b0;
        end
        repeat (dly) begin @(negedge clk); if (resp_val) early = 1; end
        check("no_early_resp", early, 0);
        is_prime_in = verdict;
        done_in     = 1'b1;
        n = 0;
        while (!resp_val && n < 3) begin @(negedge clk); n++; end
        check("resp_val", resp_val, 1);
        check("resp_is_prime", resp_is_prime, verdict);
        check("resp_timeout", resp_timeout, 0);
        unstable = 0;
        repeat (stall) begin
            @(negedge clk);
            if (resp_val !== 1'b1 || resp_is_prime !== verdict) unstable = 1;
        end
        check("resp_stable", unstable, 0);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check("resp_cleared", resp_val, 0);
        check("req_rdy_after", req_rdy, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] num;
        int         lat;
        reset = 1'b1; req_val = 1'b0; req_num = '0; resp_rdy = 1'b0;
        done_in = 1'b0; is_prime_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_sdi", sdi, 0);
        check("rst_tgl", ready_tgl, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_resp_prime", resp_is_prime, 0);
        check("rst_req_rdy", req_rdy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("req_rdy_post_rst", req_rdy, 1);

        txn(8'hA5, 1'b1, 20, 5, 0);
        txn(8'h3C, 1'b0, 20, 0, 0);
        txn(8'hC3, prime_ref(8'hC3), 10, 1, 1);
        txn(8'h00, prime_ref(0), 6, 0, 0);
        txn(8'h01, prime_ref(1), 6, 2, 0);
        txn(8'hFB, prime_ref(251), 8, 0, 0);
        for (int i = 0; i < 8; i++) begin
            num = 8'($urandom_range(0, 255));
            txn(num, prime_ref(int'(num)), $urandom_range(4, 25), $urandom_range(0, 4),
                bit'($urandom_range(0, 1)));
        end

        // reset while waiting for done
        send(8'h11, 0);
        done_in = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_tgl = 1'b0;
        check("mid_rst_cs_n", cs_n, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_tgl", ready_tgl, 0);
        check("mid_rst_resp_val", resp_val, 0);
        check("mid_rst_req_rdy", req_rdy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_req_rdy_after", req_rdy, 1);

`ifdef PRIME_FEEDER_TIMEOUT_EN
        send(8'h0B, 0);
        lat = 0;
        while (!resp_val && lat < 200) begin @(negedge clk); lat++; end
        check("tmo_latency", lat, 50);
        check("tmo_resp_val", resp_val, 1);
        check("tmo_flag", resp_timeout, 1);
        check("tmo_prime", resp_is_prime, 0);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        check("tmo_cleared", resp_val, 0);
`else
        lat = 0;
        while (lat < 60) begin @(negedge clk); lat++; end
        check("no_tmo_flag", resp_timeout, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
